// File: rtl/systolic_tile_controller_if.sv
// Command channel from the tile scheduler: valid/ready handshake plus the per-command configuration.
interface systolic_tile_controller_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned ROWS_W     = 10
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_op;
    logic [ROWS_W-1:0]     cfg_rows;
    logic [ADDR_WIDTH-1:0] cfg_rd_base;
    logic [ADDR_WIDTH-1:0] cfg_wr_base;
    logic                  cfg_accum;

    modport master (
        output cmd_valid, cmd_op, cfg_rows, cfg_rd_base, cfg_wr_base, cfg_accum,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cfg_rows, cfg_rd_base, cfg_wr_base, cfg_accum,
        output cmd_ready
    );
endinterface

// File: rtl/systolic_tile_controller.sv
// Weight-stationary systolic tile controller: weight load, activation feed with stall freeze, drain, write-back.
// Optional SYS_PERF_CNT_EN adds the FEED stall counter on stall_cnt; otherwise stall_cnt is tied to 0.
module systolic_tile_controller #(
    parameter int unsigned N_SIZE     = 32,
    parameter int unsigned MAX_ROWS   = 512,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned ROWS_W     = $clog2(MAX_ROWS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    systolic_tile_controller_if.slave   cmd_if,
    input  logic                        wt_valid,
    input  logic                        in_valid,
    output logic                        sys_wt_en,
    output logic [$clog2(N_SIZE)-1:0]   wt_row_sel,
    output logic                        sys_adv,
    output logic                        rd_en,
    output logic [ADDR_WIDTH-1:0]       rd_addr,
    output logic                        we,
    output logic [ADDR_WIDTH-1:0]       wr_addr,
    output logic                        acc_en,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        wt_loaded,
    output logic [15:0]                 stall_cnt
);
    localparam int unsigned PIPE_LAT = 2 * N_SIZE - 1;
    localparam int unsigned SEL_W    = $clog2(N_SIZE);
    localparam int unsigned ADV_W    = $clog2(MAX_ROWS + PIPE_LAT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_WT = 3'd1;
    localparam logic [2:0] S_FEED    = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    logic [2:0]            r_state,   w_state_nxt;
    logic [SEL_W-1:0]      r_wt_cnt,  w_wt_cnt_nxt;
    logic [ROWS_W-1:0]     r_beat,    w_beat_nxt;
    logic [ADV_W-1:0]      r_adv,     w_adv_nxt;
    logic [ROWS_W-1:0]     r_rows,    w_rows_nxt;
    logic [ADDR_WIDTH-1:0] r_rd_base, w_rd_base_nxt;
    logic [ADDR_WIDTH-1:0] r_wr_base, w_wr_base_nxt;
    logic                  r_accum,   w_accum_nxt;

    logic                  w_advance;
    logic                  w_wt_en_nxt, w_sys_adv_nxt, w_rd_en_nxt, w_we_nxt, w_acc_en_nxt;
    logic                  w_done_nxt, w_err_nxt, w_wt_loaded_nxt;
    logic [SEL_W-1:0]      w_row_sel_nxt;
    logic [ADDR_WIDTH-1:0] w_rd_addr_nxt, w_wr_addr_nxt;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_nxt     = r_state;
        w_wt_cnt_nxt    = r_wt_cnt;
        w_beat_nxt      = r_beat;
        w_adv_nxt       = r_adv;
        w_rows_nxt      = r_rows;
        w_rd_base_nxt   = r_rd_base;
        w_wr_base_nxt   = r_wr_base;
        w_accum_nxt     = r_accum;
        w_advance       = 1'b0;
        w_wt_en_nxt     = 1'b0;
        w_sys_adv_nxt   = 1'b0;
        w_rd_en_nxt     = 1'b0;
        w_we_nxt        = 1'b0;
        w_acc_en_nxt    = 1'b0;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_wt_loaded_nxt = wt_loaded;
        w_row_sel_nxt   = wt_row_sel;
        w_rd_addr_nxt   = rd_addr;
        w_wr_addr_nxt   = wr_addr;

        case (r_state)
            S_IDLE: begin
                if (cmd_if.cmd_valid) begin
                    w_rows_nxt    = cmd_if.cfg_rows;
                    w_rd_base_nxt = cmd_if.cfg_rd_base;
                    w_wr_base_nxt = cmd_if.cfg_wr_base;
                    w_accum_nxt   = cmd_if.cfg_accum;
                    if (!cmd_if.cmd_op) begin
                        w_state_nxt     = S_LOAD_WT;
                        w_wt_loaded_nxt = 1'b0;
                        w_wt_cnt_nxt    = '0;
                    end else if (cmd_if.cfg_rows != '0 && cmd_if.cfg_rows <= ROWS_W'(MAX_ROWS)
                                 && wt_loaded) begin
                        w_state_nxt = S_FEED;
                        w_beat_nxt  = '0;
                        w_adv_nxt   = '0;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_LOAD_WT: begin
                if (wt_valid) begin
                    w_wt_en_nxt   = 1'b1;
                    w_row_sel_nxt = r_wt_cnt;
                    w_wt_cnt_nxt  = r_wt_cnt + SEL_W'(1);
                    if (r_wt_cnt == SEL_W'(N_SIZE - 1)) begin
                        w_wt_loaded_nxt = 1'b1;
                        w_state_nxt     = S_FINISH;
                    end
                end
            end
            S_FEED: begin
                // A missing activation row freezes the whole array: no advance, counters hold.
                if (in_valid) begin
                    w_advance     = 1'b1;
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = r_rd_base + ADDR_WIDTH'(r_beat);
                    w_beat_nxt    = r_beat + ROWS_W'(1);
                    if (r_beat == r_rows - ROWS_W'(1)) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                w_advance = 1'b1;
                if (r_adv == ADV_W'(r_rows) + ADV_W'(PIPE_LAT - 1)) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Results emerge once the pipeline has filled; write index trails the advance count by PIPE_LAT.
        if (w_advance) begin
            w_sys_adv_nxt = 1'b1;
            w_adv_nxt     = r_adv + ADV_W'(1);
            if (r_adv >= ADV_W'(PIPE_LAT)) begin
                w_we_nxt      = 1'b1;
                w_acc_en_nxt  = r_accum;
                w_wr_addr_nxt = r_wr_base + ADDR_WIDTH'(r_adv - ADV_W'(PIPE_LAT));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_wt_cnt         <= '0;
            r_beat           <= '0;
            r_adv            <= '0;
            r_rows           <= '0;
            r_rd_base        <= '0;
            r_wr_base        <= '0;
            r_accum          <= 1'b0;
            cmd_if.cmd_ready <= 1'b1;
            sys_wt_en        <= 1'b0;
            wt_row_sel       <= '0;
            sys_adv          <= 1'b0;
            rd_en            <= 1'b0;
            rd_addr          <= '0;
            we               <= 1'b0;
            wr_addr          <= '0;
            acc_en           <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
            wt_loaded        <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_wt_cnt         <= w_wt_cnt_nxt;
            r_beat           <= w_beat_nxt;
            r_adv            <= w_adv_nxt;
            r_rows           <= w_rows_nxt;
            r_rd_base        <= w_rd_base_nxt;
            r_wr_base        <= w_wr_base_nxt;
            r_accum          <= w_accum_nxt;
            cmd_if.cmd_ready <= (w_state_nxt == S_IDLE);
            sys_wt_en        <= w_wt_en_nxt;
            wt_row_sel       <= w_row_sel_nxt;
            sys_adv          <= w_sys_adv_nxt;
            rd_en            <= w_rd_en_nxt;
            rd_addr          <= w_rd_addr_nxt;
            we               <= w_we_nxt;
            wr_addr          <= w_wr_addr_nxt;
            acc_en           <= w_acc_en_nxt;
            busy             <= (w_state_nxt != S_IDLE);
            done             <= w_done_nxt;
            err              <= w_err_nxt;
            wt_loaded        <= w_wt_loaded_nxt;
        end
    end

`ifdef SYS_PERF_CNT_EN
    // Saturating count of FEED cycles lost to a missing activation row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (r_state == S_IDLE && cmd_if.cmd_valid && cmd_if.cmd_op) begin
            stall_cnt <= '0;
        end else if (r_state == S_FEED && !in_valid && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_systolic_tile_controller.sv
// Scoreboard bench for systolic_tile_controller at N_SIZE=4, MAX_ROWS=16, ADDR_WIDTH=10.
module tb_systolic_tile_controller;
    localparam int unsigned N  = 4;
    localparam int unsigned MR = 16;
    localparam int unsigned AW = 10;
    localparam int unsigned RW = 5;
    localparam int unsigned PL = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wt_valid, in_valid;
    logic          sys_wt_en, sys_adv, rd_en, we, acc_en, busy, done, err, wt_loaded;
    logic [1:0]    wt_row_sel;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [15:0]   stall_cnt;

    systolic_tile_controller_if #(.ADDR_WIDTH(AW), .ROWS_W(RW)) cmd_if ();

    systolic_tile_controller #(.N_SIZE(N), .MAX_ROWS(MR), .ADDR_WIDTH(AW), .ROWS_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_if(cmd_if), .wt_valid(wt_valid), .in_valid(in_valid),
        .sys_wt_en(sys_wt_en), .wt_row_sel(wt_row_sel), .sys_adv(sys_adv), .rd_en(rd_en),
        .rd_addr(rd_addr), .we(we), .wr_addr(wr_addr), .acc_en(acc_en), .busy(busy),
        .done(done), .err(err), .wt_loaded(wt_loaded), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, adv_obs = 0, last_adv_cyc = 0, done_cyc = 0;
    int obs_wt[$], obs_rd[$], obs_wr[$];
    int exp_wt[$], exp_rd[$], exp_wr[$];

    always @(posedge clk) cyc++;

    // Record DUT events mid-cycle; write entries pack acc_en above the 10-bit address.
    always @(negedge clk) begin
        if (sys_wt_en) obs_wt.push_back(int'(wt_row_sel));
        if (rd_en)     obs_rd.push_back(int'(rd_addr));
        if (we)        obs_wr.push_back(int'(acc_en) * 4096 + int'(wr_addr));
        if (sys_adv) begin adv_obs++; last_adv_cyc = cyc; end
        if (done)    begin done_cnt++; done_cyc = cyc; end
        if (err)     err_cnt++;
    end

    task automatic clear_obs();
        obs_wt.delete(); obs_rd.delete(); obs_wr.delete();
        exp_wt.delete(); exp_rd.delete(); exp_wr.delete();
        adv_obs = 0;
    endtask

    task automatic send_cmd(input logic op, input int rows, input int rd, input int wr,
                            input logic acc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_if.cmd_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        cmd_if.cmd_valid   = ok;
        cmd_if.cmd_op      = op;
        cmd_if.cfg_rows    = RW'(rows);
        cmd_if.cfg_rd_base = AW'(rd);
        cmd_if.cfg_wr_base = AW'(wr);
        cmd_if.cfg_accum   = acc;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
    endtask

    // in_mode: 0 in_valid low, 1 held high, 2 alternating starting high.
    task automatic wait_done(input int budget, input int in_mode, output bit ok);
        int d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != d0) begin ok = 1'b1; break; end
            in_valid = (in_mode == 1) || (in_mode == 2 && (i % 2) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        wt_valid = 1'b0; in_valid = 1'b0; cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 1'b0;
        cmd_if.cfg_rows = '0; cmd_if.cfg_rd_base = '0; cmd_if.cfg_wr_base = '0; cmd_if.cfg_accum = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (cmd_if.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_if.cmd_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (wt_loaded !== 1'b0) begin n_bad++; $display("FAIL reset_wt_loaded got=%b want=0", wt_loaded); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
        n_cmp++; if ({done, err, sys_adv, rd_en, we, sys_wt_en} !== 6'b0) begin
            n_bad++; $display("FAIL reset_strobes got=%b want=000000", {done, err, sys_adv, rd_en, we, sys_wt_en});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        bit ok;
        int e, o;
        clear_obs();
        for (int r = 0; r < int'(N); r++) exp_wt.push_back(r);
        wt_valid = 1'b1;
        send_cmd(1'b0, 0, 0, 0, 1'b0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL load_accept got=timeout want=cmd_ready"); end
        wait_done(40, 0, ok);
        wt_valid = 1'b0;
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL load_done got=timeout want=done"); end
        while (exp_wt.size() > 0) begin
            e = exp_wt.pop_front();
            o = (obs_wt.size() > 0) ? obs_wt.pop_front() : -1;
            n_cmp++; if (o != e) begin n_bad++; $display("FAIL load_row_sel got=%0d want=%0d", o, e); end
        end
        n_cmp++; if (obs_wt.size() != 0) begin n_bad++; $display("FAIL load_extra_rows got=%0d want=0", obs_wt.size()); end
        n_cmp++; if (wt_loaded !== 1'b1) begin n_bad++; $display("FAIL load_wt_loaded got=%b want=1", wt_loaded); end
    endtask

    task automatic test_compute(input string nm, input int rows, input int rd, input int wr,
                                input logic acc, input bit toggle, input int exp_stall);
        bit ok;
        int e, o, e0;
        clear_obs();
        e0 = err_cnt;
        for (int k = 0; k < rows; k++) begin
            exp_rd.push_back((rd + k) % 1024);
            exp_wr.push_back(int'(acc) * 4096 + (wr + k) % 1024);
        end
        send_cmd(1'b1, rows, rd, wr, acc, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_accept got=timeout want=cmd_ready", nm); end
        wait_done(200, toggle ? 2 : 1, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_done got=timeout want=done", nm); end
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            o = (obs_rd.size() > 0) ? obs_rd.pop_front() : -1;
            n_cmp++; if (o != e) begin n_bad++; $display("FAIL %s_rd_addr got=%0d want=%0d", nm, o, e); end
        end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = (obs_wr.size() > 0) ? obs_wr.pop_front() : -1;
            n_cmp++; if (o != e) begin n_bad++; $display("FAIL %s_wr got=acc%0d/addr%0d want=acc%0d/addr%0d", nm, o / 4096, o % 4096, e / 4096, e % 4096); end
        end
        n_cmp++; if (obs_rd.size() + obs_wr.size() != 0) begin n_bad++; $display("FAIL %s_extra got=%0d want=0", nm, obs_rd.size() + obs_wr.size()); end
        n_cmp++; if (adv_obs != rows + int'(PL)) begin n_bad++; $display("FAIL %s_advances got=%0d want=%0d", nm, adv_obs, rows + int'(PL)); end
        n_cmp++; if (done_cyc != last_adv_cyc + 1) begin n_bad++; $display("FAIL %s_done_timing got=%0d want=%0d", nm, done_cyc, last_adv_cyc + 1); end
        n_cmp++; if (int'(stall_cnt) != exp_stall) begin n_bad++; $display("FAIL %s_stall_cnt got=%0d want=%0d", nm, stall_cnt, exp_stall); end
        n_cmp++; if (err_cnt != e0) begin n_bad++; $display("FAIL %s_err got=%0d want=%0d", nm, err_cnt, e0); end
    endtask

    task automatic test_errors();
        bit ok;
        int d0, e0;
        clear_obs();
        d0 = done_cnt; e0 = err_cnt;
        send_cmd(1'b1, 0, 0, 0, 1'b0, ok);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (err_cnt != e0 + 1) begin n_bad++; $display("FAIL err_rows0 got=%0d want=%0d", err_cnt, e0 + 1); end
        send_cmd(1'b1, int'(MR) + 1, 0, 0, 1'b0, ok);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (err_cnt != e0 + 2) begin n_bad++; $display("FAIL err_rows17 got=%0d want=%0d", err_cnt, e0 + 2); end
        n_cmp++; if (wt_loaded !== 1'b1) begin n_bad++; $display("FAIL err_keeps_weights got=%b want=1", wt_loaded); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_cmd(1'b1, 3, 0, 0, 1'b0, ok);
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (err_cnt != e0 + 3) begin n_bad++; $display("FAIL err_no_weights got=%0d want=%0d", err_cnt, e0 + 3); end
        n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL err_done got=%0d want=%0d", done_cnt, d0); end
        n_cmp++; if (obs_rd.size() + obs_wr.size() + adv_obs != 0) begin
            n_bad++; $display("FAIL err_activity got=%0d want=0", obs_rd.size() + obs_wr.size() + adv_obs);
        end
        n_cmp++; if (busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL err_idle got=busy%b/ready%b want=busy0/ready1", busy, cmd_if.cmd_ready);
        end
    endtask

    task automatic test_reset_in_drain();
        bit ok;
        int d0;
        test_load();
        clear_obs();
        send_cmd(1'b1, 5, 0, 0, 1'b0, ok);
        in_valid = 1'b1;
        for (int i = 0; i < 50 && obs_rd.size() < 5; i++) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1 || sys_adv !== 1'b1) begin
            n_bad++; $display("FAIL drain_reach got=busy%b/adv%b want=busy1/adv1", busy, sys_adv);
        end
        d0 = done_cnt;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++; if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL drain_rst_idle got=ready%b/busy%b want=ready1/busy0", cmd_if.cmd_ready, busy);
        end
        n_cmp++; if (wt_loaded !== 1'b0) begin n_bad++; $display("FAIL drain_rst_wt_loaded got=%b want=0", wt_loaded); end
        n_cmp++; if (sys_adv !== 1'b0 || we !== 1'b0) begin n_bad++; $display("FAIL drain_rst_adv got=%b want=0", sys_adv); end
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL drain_rst_done got=%0d want=%0d", done_cnt, d0); end
        test_load();
        test_compute("after_rst", 2, 5, 6, 1'b0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_load();
        test_compute("basic", 5, 0, 8, 1'b0, 1'b0, 0);
`ifdef SYS_PERF_CNT_EN
        test_compute("stall", 3, 20, 40, 1'b0, 1'b1, 2);
`else
        test_compute("stall", 3, 20, 40, 1'b0, 1'b1, 0);
`endif
        test_compute("wrap", 4, 1022, 1023, 1'b1, 1'b0, 0);
        test_compute("single", 1, 7, 9, 1'b1, 1'b0, 0);
        test_errors();
        test_reset_in_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
